// File: rtl/vga_fb_rect_writer.sv
// vga_fb_rect_writer: rectangle-fill write engine for a 640x480 8-bit indexed framebuffer
module vga_fb_rect_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          icmd_valid,
    output logic          ocmd_ready,
    input  logic [9:0]    ix0,
    input  logic [9:0]    iy0,
    input  logic [9:0]    iw,
    input  logic [9:0]    ih,
    input  logic [7:0]    icolor,
    input  logic          iabort,
    output logic          owren,
    output logic [AW-1:0] oaddr,
    output logic [7:0]    odata,
    output logic          obusy,
    output logic          odone
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
    state_t state;
    logic [9:0] x_start, x_cur, x_last, rows_left, ew, eh;
    logic [10:0] room_x, room_y;
    logic [AW-1:0] base, first_base, next_base;
    logic empty, row_end;

    assign room_x = 11'(H_RES) - {1'b0, ix0};
    assign room_y = 11'(V_RES) - {1'b0, iy0};
    assign ew = ({1'b0, iw} < room_x) ? iw : room_x[9:0];
    assign eh = ({1'b0, ih} < room_y) ? ih : room_y[9:0];
    assign empty = ({1'b0, ix0} >= 11'(H_RES)) | ({1'b0, iy0} >= 11'(V_RES)) | (iw == '0) | (ih == '0);
    // y0*640 as (y0<<9)+(y0<<7); later rows step the base by H_RES
    assign first_base = (AW'(iy0) << 9) + (AW'(iy0) << 7);
    assign next_base = base + AW'(H_RES);
    assign row_end = x_cur == x_last;
    assign ocmd_ready = state == S_IDLE;
    assign obusy = state != S_IDLE;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state <= S_IDLE;
            owren <= 1'b0;
            oaddr <= '0;
            odata <= '0;
            odone <= 1'b0;
            x_start <= '0;
            x_cur <= '0;
            x_last <= '0;
            rows_left <= '0;
            base <= '0;
        end else begin
            case (state)
                S_IDLE: if (icmd_valid) begin
                    state <= empty ? S_DONE : S_FILL;
                    owren <= !empty;
                    odone <= empty;
                    odata <= icolor;
                    if (!empty) begin
                        x_start <= ix0;
                        x_cur <= ix0;
                        x_last <= ix0 + ew - 10'd1;
                        rows_left <= eh - 10'd1;
                        base <= first_base;
                        oaddr <= first_base + AW'(ix0);
                    end
                end
                // the write presented this cycle completes even when aborting
                S_FILL: if (iabort || (row_end && rows_left == '0)) begin
                    state <= S_DONE;
                    owren <= 1'b0;
                    odone <= 1'b1;
                end else if (row_end) begin
                    x_cur <= x_start;
                    rows_left <= rows_left - 10'd1;
                    base <= next_base;
                    oaddr <= next_base + AW'(x_start);
                end else begin
                    x_cur <= x_cur + 10'd1;
                    oaddr <= base + AW'(x_cur + 10'd1);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    odone <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_rect_writer.sv
// tb_vga_fb_rect_writer: scoreboard bench for the framebuffer rectangle writer
module tb_vga_fb_rect_writer;
    logic iclk = 1'b0, irst = 1'b1, icmd_valid = 1'b0, iabort = 1'b0;
    logic [9:0] ix0 = '0, iy0 = '0, iw = '0, ih = '0;
    logic [7:0] icolor = '0;
    logic ocmd_ready, owren, obusy, odone;
    logic [18:0] oaddr;
    logic [7:0] odata;
    int total = 0, bad = 0, cyc = 0, last_done = 0, seen_done = -10;
    typedef struct {int addr; int data;} wr_t;
    wr_t exp_q[$];
    int done_q[$];

    vga_fb_rect_writer dut (
        .iclk(iclk), .irst(irst), .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
        .ix0(ix0), .iy0(iy0), .iw(iw), .ih(ih), .icolor(icolor), .iabort(iabort),
        .owren(owren), .oaddr(oaddr), .odata(odata), .obusy(obusy), .odone(odone)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_wren"}, int'(owren), 0);
        check({nm, "_done"}, int'(odone), 0);
        check({nm, "_addr"}, int'(oaddr), 0);
        check({nm, "_data"}, int'(odata), 0);
        check({nm, "_busy"}, int'(obusy), 0);
        check({nm, "_ready"}, int'(ocmd_ready), 1);
    endtask

    // monitor: every presented write and done pulse is matched against the scoreboard
    always @(negedge iclk) if (!irst) begin
        if (owren) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(oaddr), e.addr);
                check("wr_data", int'(odata), e.data);
                check("wr_ready_low", int'(ocmd_ready), 0);
                check("wr_busy", int'(obusy), 1);
            end
        end
        if (odone) begin
            seen_done = cyc;
            if (done_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                check("done_cycle", cyc, done_q.pop_front());
                check("done_no_write", int'(owren), 0);
                check("done_ready_low", int'(ocmd_ready), 0);
            end
        end else if (cyc == seen_done + 1) begin
            check("ready_after_done", int'(ocmd_ready), 1);
            check("idle_not_busy", int'(obusy), 0);
        end
    end

    // ab>0: raise iabort while write ab is presented; rs>0: pulse irst after rs writes
    task automatic cmd(input int x0, input int y0, input int w, input int h, input int c,
                       input int ab, input int rs, input bit hold, input bit chk);
        int a, n, m, k;
        k = 0;
        while (k < 60000) begin
            @(negedge iclk);
            if (ocmd_ready) break;
            k++;
        end
        if (k >= 60000) check("ready_timeout", 0, 1);
        ix0 = 10'(x0); iy0 = 10'(y0); iw = 10'(w); ih = 10'(h); icolor = 8'(c);
        icmd_valid = 1'b1;
        @(posedge iclk);
        #1;
        a = cyc;
        if (!hold) icmd_valid = 1'b0;
        if (chk) check("accept_cycle", a, last_done + 2);
        n = 0;
        m = (ab > 0) ? ab : (rs > 0 ? rs : 1 << 30);
        for (int yy = y0; yy < y0 + h && yy < 480; yy++)
            for (int xx = x0; xx < x0 + w && xx < 640; xx++)
                if (n < m) begin
                    exp_q.push_back(wr_t'{yy * 640 + xx, c});
                    n++;
                end
        if (rs == 0) begin
            done_q.push_back(a + n);
            last_done = a + n;
        end
        if (ab > 0) begin
            repeat (ab - 1) @(posedge iclk);
            #1 iabort = 1'b1;
            @(posedge iclk);
            #1 iabort = 1'b0;
        end
        if (rs > 0) begin
            repeat (rs) @(posedge iclk);
            #2 irst = 1'b1;
            #1 check_reset_outputs("midfill_rst");
            @(negedge iclk);
            #2 irst = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ph, hd;
        int ab, x0, y0;
        #12 check_reset_outputs("reset");
        @(negedge iclk);
        #2 irst = 1'b0;
        cmd(10, 2, 3, 2, 8'h55, 0, 0, 0, 0);
        cmd(638, 479, 5, 3, 8'hAA, 0, 0, 0, 0);
        cmd(5, 5, 0, 3, 8'h01, 0, 0, 1, 0);
        cmd(640, 0, 4, 4, 8'h02, 0, 0, 1, 1);
        cmd(3, 480, 2, 2, 8'h03, 0, 0, 0, 1);
        cmd(0, 440, 640, 200, 8'h00, 0, 0, 0, 0);
        cmd(0, 0, 640, 480, 8'h33, 100, 0, 0, 0);
        cmd(0, 0, 640, 480, 8'h77, 0, 50, 0, 0);
        cmd(100, 100, 5, 3, 8'h11, 0, 0, 1, 0);
        cmd(630, 200, 20, 2, 8'h22, 0, 0, 1, 1);
        cmd(0, 479, 3, 4, 8'h44, 0, 0, 0, 1);
        ph = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hd = (i < 59) && ($urandom % 2 == 1);
            ab = (!hd && $urandom % 4 == 0) ? int'($urandom_range(1, 12)) : 0;
            x0 = ($urandom % 4 == 0) ? int'($urandom_range(600, 660)) : int'($urandom_range(0, 639));
            y0 = ($urandom % 4 == 0) ? int'($urandom_range(470, 485)) : int'($urandom_range(0, 479));
            cmd(x0, y0, int'($urandom_range(0, 40)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 255)), ab, 0, hd, ph);
            if (!hd) repeat ($urandom % 3) @(posedge iclk);
            ph = hd;
        end
        icmd_valid = 1'b0;
        repeat (20) @(posedge iclk);
        @(negedge iclk);
        check("pending_writes", exp_q.size(), 0);
        check("pending_done", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
